// File: rtl/accu_serializer.sv
// Serializes one GROUP-byte parallel word into LSB-first beats with last marker and group sum.
// Beat 0 is visible one edge after load; ready_in low holds the current beat, grp_ready reopens on the final beat.
module accu_serializer #(
  parameter int DATA_W = 8,
  parameter int GROUP  = 4,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [GROUP*DATA_W-1:0] grp_in,
  input  logic                    grp_valid,
  output logic                    grp_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    last_out,
  output logic [SUM_W-1:0]        sum_out,
  output logic [CNT_W-1:0]        grp_count
);

  localparam int BEAT_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(GROUP - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [GROUP*DATA_W-1:0]   r_shift;
  logic [BEAT_W-1:0]         r_beat;
  logic [DATA_W-1:0]         r_data;
  logic                      r_last;
  logic [SUM_W-1:0]          r_sum;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_ready;
  logic                      w_consume;
  logic                      w_done;
  logic                      w_load;
  logic [SUM_W-1:0]          w_node [1:2*GROUP-1];

  // Heap-indexed adder tree: leaves at GROUP..2*GROUP-1, root at node 1.
  always_comb begin
    for (int i = 0; i < GROUP; i++) begin
      w_node[GROUP+i] = SUM_W'(grp_in[i*DATA_W +: DATA_W]);
    end
    for (int i = GROUP - 1; i >= 1; i--) begin
      w_node[i] = w_node[2*i] + w_node[2*i+1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_consume   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (grp_valid) w_state_nxt = SEND;
      end
      SEND: begin
        w_consume = ready_in;
        w_done    = ready_in && (r_beat == LAST_BEAT);
        w_ready   = w_done;
        if (w_done && !grp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load = grp_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_beat  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data  <= grp_in[DATA_W-1:0];
        r_shift <= grp_in >> DATA_W;
        r_beat  <= '0;
        r_last  <= 1'b0;
        r_sum   <= w_node[1];
      end else if (w_consume && !w_done) begin
        r_data  <= r_shift[DATA_W-1:0];
        r_shift <= r_shift >> DATA_W;
        r_beat  <= r_beat + 1'b1;
        r_last  <= (r_beat == LAST_BEAT - 1'b1);
      end else if (w_done) begin
        // Group drained with nothing queued: data_out keeps its last byte.
        r_last  <= 1'b0;
      end
      if (w_done) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign grp_ready = w_ready;
  assign data_out  = r_data;
  assign valid_out = (r_state == SEND);
  assign last_out  = r_last;
  assign sum_out   = r_sum;
  assign grp_count = r_cnt;

endmodule

// File: doc/accu_serializer.md
Name: accu_serializer

Overview:
- Transmit-side companion to the 4-beat accumulator: accepts one parallel group of GROUP bytes and emits it as a serial byte stream with valid, so it can drive an accumulator's data_in/valid_in directly.
- Also presents the expected group sum and a last-beat marker, so downstream accumulated results can be cross-checked in-system.
- Sits between a wide producer (register/FIFO) and the accumulation datapath.

Parameters:
- DATA_W, 8, width of one serial beat
- GROUP, 4, beats per group (power of two, >=2)
- SUM_W, 10, width of expected-sum output; must equal DATA_W + log2(GROUP)
- CNT_W, 16, width of the sent-group counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- grp_in  input  GROUP*DATA_W  parallel group; byte k = grp_in[k*DATA_W +: DATA_W]
- grp_valid  input  1  grp_in is valid
- grp_ready  output  1  block accepts grp_in this cycle (combinational)
- data_out  output  DATA_W  current serial beat (registered)
- valid_out  output  1  data_out is valid (registered)
- ready_in  input  1  downstream accepts the beat; tie high for an always-ready sink
- last_out  output  1  current beat is the final beat of its group (registered)
- sum_out  output  SUM_W  zero-extended sum of all bytes of the group being sent (registered)
- grp_count  output  CNT_W  number of groups fully sent, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst sampled high at a clk edge) clears outputs and state:
  - valid_out=0, data_out=0, last_out=0, sum_out=0, grp_count=0
  - beat index=0, FSM=IDLE
  - Reset wins over every other event. An in-flight group is discarded and is not counted.
- Handshake:
  - A group is loaded at an edge where grp_valid && grp_ready.
  - A beat is consumed at an edge where valid_out && ready_in.
- FSM has two states, IDLE and SEND.
  - IDLE:
    - grp_ready=1, valid_out=0.
    - On load: capture grp_in into a shift register and compute sum_out.
    - data_out becomes byte 0, valid_out=1, beat=0, and the FSM moves to SEND.
    - Latency: the group is loaded at edge N and beat 0 is visible after edge N.
  - SEND:
    - valid_out=1.
    - grp_ready = ready_in && (beat==GROUP-1).
    - Beat consumed and beat<GROUP-1: shift, data_out becomes the next byte (byte order 0..GROUP-1, LSB byte first), beat increments.
    - Beat consumed and beat==GROUP-1: grp_count increments, with wrap.
      - If grp_valid is also high, the next group loads in the same edge with no bubble; the FSM stays in SEND and beat returns to 0.
      - Otherwise the FSM returns to IDLE, valid_out=0, and data_out holds its last value.
    - ready_in low: data_out, last_out, sum_out and beat hold. valid_out stays 1; a beat is never withdrawn.
- last_out = valid_out && beat==GROUP-1, registered alongside data_out.
- sum_out:
  - Computed as an adder tree over the GROUP bytes, each zero-extended to SUM_W. It cannot overflow (max GROUP*(2^DATA_W-1)).
  - Updated only at group load and held stable for every beat of the group.
  - Retains its value in IDLE.
- grp_valid while in SEND with beat<GROUP-1: ignored, since grp_ready=0. The producer must hold grp_valid and grp_in.
- grp_in changing while grp_ready=0 has no effect.
- Throughput: one group per GROUP cycles with ready_in held high and grp_valid held high.

Test Plan:
- Single group: grp_in=0x04030201, ready_in=1.
  - Required: data_out 01,02,03,04 on 4 consecutive cycles, valid_out=1 for exactly those 4 cycles.
  - last_out=1 only on beat 04; sum_out=0x00A throughout; grp_count 0->1 after the last beat.
- Max values: grp_in=0xFFFFFFFF.
  - Required: beats FF×4, sum_out=0x3FC with no overflow.
  - Feeding the stream into the accumulator yields data_out 0x3FC there.
- Back-to-back: grp_valid held high with groups 0x04030201 then 0x80808080.
  - Required: 8 consecutive valid beats with no bubble; grp_ready pulses only on the cycles of beat 0 (IDLE) and beat 3.
  - sum_out switches 0x00A->0x200 at the start of the second group.
- Backpressure: group 0x04030201, ready_in=0 for 3 cycles while data_out=03.
  - Required: data_out=03, valid_out=1, last_out=0 held for 3 cycles; stream then resumes with 04 and last_out=1.
- Load blocked mid-group: grp_valid=1 with grp_in=0xAAAAAAAA while beat 1 is showing.
  - Required: grp_ready=0, current group unaffected; the new group loads only on the beat-3 handshake.
- Reset mid-operation: assert rst for one cycle while beat 2 is showing.
  - Required: next cycle valid_out=0, data_out=0, sum_out=0, grp_count unchanged from 0, grp_ready=1.
  - A new group then sends from byte 0.
